// File: rtl/cv32e40p_clock_gate_ctrl_if.sv
// Activity, wake and gated-clock bundle between the core sub-units and the gating controller.
// The master drives requests and thresholds; the controller is the slave.
interface cv32e40p_clock_gate_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  logic              scan_cg_en_i;
  logic [CNT_W-1:0]  idle_thresh_i;
  logic [NUM_CH-1:0] auto_en_i;
  logic [NUM_CH-1:0] busy_i;
  logic [NUM_CH-1:0] force_on_i;
  logic [NUM_CH-1:0] wake_req_i;
  logic [NUM_CH-1:0] wake_ack_o;
  logic [NUM_CH-1:0] gated_o;
  logic              all_gated_o;
  logic [NUM_CH-1:0] clk_o;

  modport master (
    output scan_cg_en_i, idle_thresh_i, auto_en_i, busy_i, force_on_i, wake_req_i,
    input  wake_ack_o, gated_o, all_gated_o, clk_o
  );

  modport slave (
    input  scan_cg_en_i, idle_thresh_i, auto_en_i, busy_i, force_on_i, wake_req_i,
    output wake_ack_o, gated_o, all_gated_o, clk_o
  );
endinterface

// File: rtl/cv32e40p_clock_gate_ctrl.sv
// Per-channel idle-count clock gating: clock stops one cycle after the gating edge,
// wake ack follows WAKE_CYCLES after leaving GATED; no backpressure, requests are levels.

module cv32e40p_clock_gate (
  input  logic clk_i,
  input  logic en_i,
  input  logic scan_cg_en_i,
  output logic clk_o
);
  logic en_l;

  // Latch is transparent only while clk_i is low, so clk_o never glitches.
  always_latch begin
    if (!clk_i) en_l = en_i | scan_cg_en_i;
  end

  assign clk_o = clk_i & en_l;
endmodule

module cv32e40p_clock_gate_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  cv32e40p_clock_gate_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_GATED = 2'd1,
    ST_WAKE  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] en_q;
  logic [NUM_CH-1:0] ack_q;
  logic [NUM_CH-1:0] ack_d;
  logic [NUM_CH-1:0] req_q;
  logic [NUM_CH-1:0] keep;

  assign keep = bus.busy_i | bus.force_on_i | bus.wake_req_i | ~bus.auto_en_i
              | {NUM_CH{bus.idle_thresh_i == '0}};

  always_comb begin
    ack_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_RUN: begin
          if (keep[i]) begin
            cnt_d[i] = '0;
            ack_d[i] = bus.wake_req_i[i] & ~req_q[i];
          end else if (cnt_q[i] + CNT_W'(1) == bus.idle_thresh_i) begin
            state_d[i] = ST_GATED;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        ST_GATED: begin
          if (keep[i]) begin
            state_d[i] = ST_WAKE;
            cnt_d[i]   = '0;
          end
        end
        ST_WAKE: begin
          // Inputs are deliberately ignored until the wake sequence completes.
          if (cnt_q[i] == WAKE_LAST) begin
            state_d[i] = ST_RUN;
            cnt_d[i]   = '0;
            ack_d[i]   = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = ST_RUN;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_RUN;
        cnt_q[i]   <= '0;
      end
      en_q  <= '1;
      ack_q <= '0;
      req_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        en_q[i]    <= (state_d[i] != ST_GATED);
      end
      ack_q <= ack_d;
      req_q <= bus.wake_req_i;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign bus.gated_o[g] = (state_q[g] == ST_GATED);

    cv32e40p_clock_gate u_cg (
      .clk_i        (clk_i),
      .en_i         (en_q[g]),
      .scan_cg_en_i (bus.scan_cg_en_i),
      .clk_o        (bus.clk_o[g])
    );
  end

  assign bus.wake_ack_o  = ack_q;
  assign bus.all_gated_o = &bus.gated_o;
endmodule
